mul_seq: RTL and testbench

//  Multi-cycle controller for MULT/MULTU: produces a 2*WIDTH-bit product in HI/LO by shift-add.
//  It owns one external WIDTH-bit adder instance (s = a + b, no carry-out) and sequences it.
//  The adder is used for operand absolute values, the partial-sum adds and the final 64-bit negate.
//  It sits beside the ALU in EX; the pipeline stalls on busy and flushes via cancel.

---
 rtl/mul_seq_if.sv | 25 ++
 rtl/mul_seq.sv | 159 +++++++++++++++
 tb/tb_mul_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_if.sv
// Request/response bundle between the EX-stage pipeline and the sequential multiplier.
// The pipeline side is the master; mul_seq is the slave.
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, op_a, op_b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_seq.sv
// Multi-cycle shift-add MULT/MULTU controller sharing one external WIDTH-bit adder.
// Signed operands are made positive first and the 2*WIDTH-bit product negated at the end.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  mul_seq_if.slave         bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ABS_A,
    ABS_B,
    RUN,
    NEG_LO,
    NEG_HI,
    DONE
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [CW-1:0]    cnt_reg;
  logic             neg_reg;
  logic             cy_reg;
  logic             sb_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             sa;
  logic             sb;
  logic             carry;
  logic             last_bit;

  assign sa       = bus.is_signed & bus.op_a[WIDTH-1];
  assign sb       = bus.is_signed & bus.op_b[WIDTH-1];
  // The adder has no carry-out; an unsigned wrap shows up as a sum below an operand.
  assign carry    = (add_s < add_a);
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_reg)
      ABS_A: begin
        add_a = ~mcand_reg;
        add_b = WIDTH'(1);
      end
      ABS_B: begin
        add_a = ~lo_reg;
        add_b = WIDTH'(1);
      end
      RUN: begin
        add_a = hi_reg;
        add_b = lo_reg[0] ? mcand_reg : '0;
      end
      NEG_LO: begin
        add_a = ~lo_reg;
        add_b = WIDTH'(1);
      end
      NEG_HI: begin
        add_a = ~hi_reg;
        add_b = {{(WIDTH-1){1'b0}}, cy_reg};
      end
      default: begin
        add_a = '0;
        add_b = '0;
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (bus.cancel) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (sa)      state_next = ABS_A;
            else if (sb) state_next = ABS_B;
            else         state_next = RUN;
          end
        end
        ABS_A:   state_next = sb_reg ? ABS_B : RUN;
        ABS_B:   state_next = RUN;
        RUN: begin
          if (last_bit) state_next = neg_reg ? NEG_LO : DONE;
        end
        NEG_LO:  state_next = NEG_HI;
        NEG_HI:  state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      cnt_reg   <= '0;
      neg_reg   <= 1'b0;
      cy_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
      if (!bus.cancel) begin
        case (state_reg)
          IDLE: begin
            if (bus.start) begin
              mcand_reg <= bus.op_a;
              lo_reg    <= bus.op_b;
              hi_reg    <= '0;
              cnt_reg   <= '0;
              neg_reg   <= sa ^ sb;
              sb_reg    <= sb;
            end
          end
          ABS_A:  mcand_reg <= add_s;
          ABS_B:  lo_reg    <= add_s;
          // Shift the carry and new partial sum into hi while the consumed multiplier bit leaves lo.
          RUN: begin
            hi_reg  <= {carry, add_s[WIDTH-1:1]};
            lo_reg  <= {add_s[0], lo_reg[WIDTH-1:1]};
            cnt_reg <= cnt_reg + CW'(1);
          end
          NEG_LO: begin
            lo_reg <= add_s;
            cy_reg <= (lo_reg == '0);
          end
          NEG_HI: hi_reg <= add_s;
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: table of multiplies with hand-computed products and DONE cycles,
// plus cancel, start-while-busy and mid-operation reset sequences.
module tb_mul_seq;

  localparam int W = 32;

  logic         clk;
  logic         resetn;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_s;

  mul_seq_if #(.WIDTH(W)) bus ();

  mul_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_s  (add_s)
  );

  assign add_s = add_a + add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_cyc;
  } vec_t;

  vec_t vecs[11];
  int   checks;
  int   failures;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Issue one op starting in the current cycle (cycle 0) and wait for its done pulse.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int exp_cyc);
    int done_cyc;
    int busy_low;
    done_cyc = -1;
    busy_low = 0;
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.op_a      = a;
    bus.op_b      = b;
    step();
    bus.start     = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      step();
    end
    chk({name, " done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    chk({name, " busy_gaps"}, 64'(busy_low), 64'd0);
    chk({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
    step();
    chk({name, " done_pulse_end"}, {62'd0, bus.done, bus.busy}, 64'd0);
    $display("op %s a=%h b=%h signed=%0b -> hi=%h lo=%h done_cycle=%0d",
             name, a, b, sgn, bus.hi, bus.lo, done_cyc);
  endtask

  initial begin
    int n_done;
    checks   = 0;
    failures = 0;
    resetn        = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.cancel    = 1'b0;

    vecs[0]  = '{32'd3,        32'd5,        1'b0, 32'h0,        32'hF,        33};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[2]  = '{32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 36};
    vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0,        35};
    vecs[4]  = '{32'd0,        32'hFFFFFFF9, 1'b1, 32'h0,        32'h0,        36};
    vecs[5]  = '{32'd7,        32'd9,        1'b0, 32'h0,        32'd63,       33};
    vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h1,        35};
    vecs[7]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF2, 36};
    vecs[8]  = '{32'h80000000, 32'd2,        1'b0, 32'h1,        32'h0,        33};
    vecs[9]  = '{32'h12345678, 32'h10,       1'b1, 32'h1,        32'h23456780, 33};
    vecs[10] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 32'h80000000, 33};

    step();
    step();
    chk("reset_hi_lo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("reset_adder_ops", {add_a, add_b}, 64'd0);
    resetn = 1'b1;
    step();
    chk("idle_after_reset", {62'd0, bus.busy, bus.done}, 64'd0);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_cyc);
    end

    // Cancel during RUN cycle 10, then restart immediately in cycle 11.
    n_done = 0;
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.op_a      = 32'd7;
    bus.op_b      = 32'd9;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (bus.done === 1'b1) n_done++;
      step();
    end
    if (bus.done === 1'b1) n_done++;
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    chk("cancel_idle_c11", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("cancel_no_done", 64'(n_done), 64'd0);
    $display("op cancel 7*9 in RUN cycle 10 -> busy=%0b done=%0b", bus.busy, bus.done);
    run_op("restart_7x9", 32'd7, 32'd9, 1'b0, 32'd0, 32'd63, 33);

    // Hold start high through the whole op with changing operands; only the first is taken.
    n_done = 0;
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.op_a      = 32'd3;
    bus.op_b      = 32'd5;
    step();
    for (int c = 1; c <= 33; c++) begin
      bus.op_a = 32'hDEAD0000 + 32'(c);
      bus.op_b = 32'h0BAD0000 + 32'(c);
      if (bus.done === 1'b1) begin
        n_done++;
        chk("busy_start_hi", 64'(bus.hi), 64'd0);
        chk("busy_start_lo", 64'(bus.lo), 64'hF);
        chk("busy_start_cycle", 64'(c), 64'd33);
      end
      if (c == 33) bus.start = 1'b0;
      step();
    end
    for (int c = 34; c <= 40; c++) begin
      if (bus.done === 1'b1) n_done++;
      step();
    end
    chk("busy_start_one_done", 64'(n_done), 64'd1);
    $display("op start-held 3*5 -> dones=%0d hi=%h lo=%h", n_done, bus.hi, bus.lo);

    // Asynchronous reset in the middle of RUN.
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.op_a      = 32'hFFFFFFFF;
    bus.op_b      = 32'hFFFFFFFF;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    chk("pre_reset_busy", 64'(bus.busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("async_reset_hi_lo", {bus.hi, bus.lo}, 64'd0);
    chk("async_reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    #2;
    resetn = 1'b1;
    step();
    step();
    chk("post_reset_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    $display("op reset mid-RUN -> hi=%h lo=%h busy=%0b", bus.hi, bus.lo, bus.busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
